light_seq: RTL and testbench
============================

# light_seq

Parametrised, programmable light-pattern sequencer. It steps through a table of up to STEPS entries, each holding a WIDTH-bit light pattern and a per-step dwell time. It supports loop, one-shot and ping-pong modes, pause and stop controls, and a clock-enable tick for rate control. It drives a board LED/lamp bank directly and is configured at run time by a small register-write port.

## Interface
- WIDTH, 6, light pattern width
- STEPS, 8, table depth (≥2); SW = $clog2(STEPS)
- DWELL_W, 8, dwell counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  rate enable; one pulse = one time unit
- start  in  1  start/restart sequence (single-cycle pulse)
- stop  in  1  abort to IDLE
- pause  in  1  level; freezes dwell count and step
- mode  in  2  0 loop, 1 one-shot, 2 ping-pong, 3 = loop; sampled on start
- last_step  in  SW  index of final step; sampled on start; values >STEPS-1 clamp to STEPS-1
- wr_en  in  1  table write strobe
- wr_addr  in  SW  table index
- wr_pattern  in  WIDTH  pattern to write
- wr_dwell  in  DWELL_W  dwell to write (step lasts wr_dwell+1 ticks)
- light  out  WIDTH  registered pattern output
- step  out  SW  current step index
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at one-shot completion

## Operation
- Reset values: state IDLE, light 0, step 0, busy 0, done 0, direction up, dwell counter 0, every table entry pattern 0 and dwell 0.
- States:
  - IDLE: light 0, step 0. start → RUN.
  - RUN: counts ticks and advances steps.
- Load of step k: step ← k, light ← pattern[k], cnt ← dwell[k].
- start: latches mode and last_step (clamped to L), sets direction up, loads step 0, enters RUN. start while RUN restarts the same way.
- RUN, on a tick with pause low:
  - cnt≠0: cnt−1.
  - cnt=0: advance according to mode.
    - Loop: step<L → load step+1; step=L → load 0.
    - One-shot: step<L → load step+1; step=L → go to IDLE (light 0, step 0, busy 0) and pulse done for 1 cycle.
    - Ping-pong, direction up: step<L → step+1; step=L → flip direction and load L−1.
    - Ping-pong, direction down: step>0 → step−1; step=0 → flip direction and load 1.
    - Ping-pong with L=0: stays at step 0 and does not flip.
- L=0 in loop: reloads step 0 each expiry. L=0 in one-shot: finishes after step 0 dwell.
- pause high: ticks are ignored. light, step and cnt hold. start/stop still act.
- stop: go to IDLE; light, step, busy, direction and cnt take their reset values; done is not pulsed.
- Priority: stop > start > tick. A tick in the same cycle as start is ignored.
- Writes: accepted in any state; they update the table on the clock edge. light reflects a table change only at the next load of that step. If a write and a load hit the same entry in the same cycle, the load uses the old value.

## Timing
- start sampled in cycle n → busy=1 and light=pattern[0] from cycle n+1.
- Each step lasts exactly dwell+1 unpaused ticks. light changes in the cycle after the expiring tick.
- One-shot: the expiring tick on step L in cycle m → light=0, busy=0, done=1 in cycle m+1; done=0 in cycle m+2.
- stop in cycle n → IDLE outputs from n+1.
- rst is asserted asynchronously and takes effect immediately, including mid-sequence; rst deassertion must be synchronised by the board reset block.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset mid-RUN on step 3 → light 0, step 0, busy 0, done 0 immediately; table reads back as zero (all steps show light 0 after start).
- Loop: WIDTH=6, entries 0..2 = 111111/101010/100011, dwell 0,1,2, L=2, tick every cycle → light sequence 111111×1, 101010×2, 100011×3, then repeats; step 0,1,1,2,2,2,0…
- One-shot: same table, mode 1 → done pulses for exactly 1 cycle after the third 100011 cycle; light 0, busy 0 afterwards; further ticks have no effect.
- Ping-pong: L=3, all dwell 0 → step sequence 0,1,2,3,2,1,0,1,…; L=0 → step stays 0.
- Pause/stop/start collisions:
  - pause for 5 ticks mid-dwell → step and light frozen, then resumes with the remaining count.
  - stop and start in the same cycle → IDLE.
  - start in the same cycle as a tick → step 0 holds for its full dwell+1.
- Write hazards:
  - writing the current step during RUN → light unchanged until that step reloads.
  - last_step=15 with STEPS=8 → wraps after step 7.

Source files
------------

// File: rtl/light_seq.sv
// Programmable light-pattern sequencer: a STEPS-entry table of pattern/dwell
// pairs played back in loop, one-shot or ping-pong order, paced by tick.
module light_seq #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned STEPS   = 8,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned SW      = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [1:0]         mode,
  input  logic [SW-1:0]      last_step,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_pattern,
  input  logic [DWELL_W-1:0] wr_dwell,
  output logic [WIDTH-1:0]   light,
  output logic [SW-1:0]      step,
  output logic               busy,
  output logic               done
);

  typedef enum logic { IDLE, RUN } state_t;
  typedef enum logic { UP, DOWN } dir_t;
  typedef enum logic [1:0] {
    M_LOOP    = 2'd0,
    M_ONESHOT = 2'd1,
    M_PING    = 2'd2,
    M_LOOP3   = 2'd3
  } mode_t;

  localparam logic [SW-1:0] MAX_STEP = SW'(STEPS - 1);

  state_t               state;
  dir_t                 dir;
  mode_t                mode_r;
  logic [SW-1:0]        last_r;
  logic [DWELL_W-1:0]   cnt;

  logic [WIDTH-1:0]     pat_mem [STEPS];
  logic [DWELL_W-1:0]   dw_mem  [STEPS];

  logic [SW-1:0]        last_clamp;
  logic [SW-1:0]        nxt_step;
  dir_t                 nxt_dir;
  logic                 fin;

  always_comb begin
    last_clamp = (last_step > MAX_STEP) ? MAX_STEP : last_step;
  end

  // Successor of the current step once its dwell has expired.
  always_comb begin
    nxt_step = step;
    nxt_dir  = dir;
    fin      = 1'b0;
    case (mode_r)
      M_ONESHOT: begin
        if (step < last_r) nxt_step = step + SW'(1);
        else               fin      = 1'b1;
      end
      M_PING: begin
        if (last_r == '0) begin
          nxt_step = '0;
        end else if (dir == UP) begin
          if (step < last_r) begin
            nxt_step = step + SW'(1);
          end else begin
            nxt_dir  = DOWN;
            nxt_step = last_r - SW'(1);
          end
        end else begin
          if (step != '0) begin
            nxt_step = step - SW'(1);
          end else begin
            nxt_dir  = UP;
            nxt_step = SW'(1);
          end
        end
      end
      default: begin
        nxt_step = (step < last_r) ? step + SW'(1) : '0;
      end
    endcase
  end

  // Table reads in the control block see pre-write contents, so a load
  // coinciding with a write to the same entry picks up the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < STEPS; i++) begin
        pat_mem[i] <= '0;
        dw_mem[i]  <= '0;
      end
    end else if (wr_en && (wr_addr <= MAX_STEP)) begin
      pat_mem[wr_addr] <= wr_pattern;
      dw_mem[wr_addr]  <= wr_dwell;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dir    <= UP;
      mode_r <= M_LOOP;
      last_r <= '0;
      cnt    <= '0;
      light  <= '0;
      step   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        dir   <= UP;
        cnt   <= '0;
        light <= '0;
        step  <= '0;
        busy  <= 1'b0;
      end else if (start) begin
        state  <= RUN;
        mode_r <= mode_t'(mode);
        last_r <= last_clamp;
        dir    <= UP;
        step   <= '0;
        light  <= pat_mem[0];
        cnt    <= dw_mem[0];
        busy   <= 1'b1;
      end else if (state == RUN && tick && !pause) begin
        if (cnt != '0) begin
          cnt <= cnt - DWELL_W'(1);
        end else if (fin) begin
          state <= IDLE;
          dir   <= UP;
          light <= '0;
          step  <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          step  <= nxt_step;
          dir   <= nxt_dir;
          light <= pat_mem[nxt_step];
          cnt   <= dw_mem[nxt_step];
        end
      end
    end
  end

endmodule

// File: tb/tb_light_seq.sv
// Directed bench for light_seq: vector tables for the playback modes plus
// hand-written sequences for reset, pause, collisions and table-write hazards.
module tb_light_seq;
  localparam int unsigned WIDTH   = 6;
  localparam int unsigned STEPS   = 8;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned SW      = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick, start, stop, pause;
  logic [1:0]         mode;
  logic [SW-1:0]      last_step;
  logic               wr_en;
  logic [SW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_pattern;
  logic [DWELL_W-1:0] wr_dwell;
  logic [WIDTH-1:0]   light;
  logic [SW-1:0]      step;
  logic               busy, done;

  light_seq #(.WIDTH(WIDTH), .STEPS(STEPS), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .mode(mode), .last_step(last_step), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_pattern(wr_pattern), .wr_dwell(wr_dwell),
    .light(light), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             tk, st, sp, ps;
    logic [1:0]       md;
    logic [SW-1:0]    ls;
    logic [WIDTH-1:0] e_light;
    logic [SW-1:0]    e_step;
    logic             e_busy, e_done;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic [WIDTH-1:0] l, input logic [SW-1:0] s,
                         input logic b, input logic d);
    chk({tag, ".light"}, 32'(light), 32'(l));
    chk({tag, ".step"},  32'(step),  32'(s));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  task automatic clr();
    tick = 0; start = 0; stop = 0; pause = 0; wr_en = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] p, input int d);
    wr_en = 1; wr_addr = SW'(a); wr_pattern = p; wr_dwell = DWELL_W'(d);
    cyc();
    wr_en = 0;
  endtask

  task automatic add(input logic tk, input logic st, input logic sp, input logic ps,
                     input int md, input int ls, input logic [WIDTH-1:0] l,
                     input int s, input logic b, input logic d);
    vec_t v;
    v.tk = tk; v.st = st; v.sp = sp; v.ps = ps; v.md = 2'(md); v.ls = SW'(ls);
    v.e_light = l; v.e_step = SW'(s); v.e_busy = b; v.e_done = d;
    vq.push_back(v);
  endtask

  task automatic tk(input logic [WIDTH-1:0] l, input int s);
    add(1, 0, 0, 0, 0, 0, l, s, 1, 0);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      tick = vq[i].tk; start = vq[i].st; stop = vq[i].sp; pause = vq[i].ps;
      mode = vq[i].md; last_step = vq[i].ls;
      cyc();
      chk_out($sformatf("%s[%0d]", tag, i), vq[i].e_light, vq[i].e_step,
              vq[i].e_busy, vq[i].e_done);
    end
    vq.delete();
    clr();
  endtask

  initial begin
    int lval;
    rst = 1; clr(); mode = 0; last_step = 0;
    wr_addr = 0; wr_pattern = 0; wr_dwell = 0;
    #2 rst = 0;
    #1 chk_out("reset", '0, 0, 0, 0);
    @(negedge clk); rst = 1;
    cyc();

    // Loop, then one-shot over the same three-entry table.
    wr(0, 6'b111111, 0); wr(1, 6'b101010, 1); wr(2, 6'b100011, 2);
    add(1, 1, 0, 0, 0, 2, 6'b111111, 0, 1, 0);
    tk(6'b101010, 1); tk(6'b101010, 1);
    tk(6'b100011, 2); tk(6'b100011, 2); tk(6'b100011, 2);
    tk(6'b111111, 0); tk(6'b101010, 1); tk(6'b101010, 1); tk(6'b100011, 2);
    run_vecs("loop");

    add(1, 1, 0, 0, 1, 2, 6'b111111, 0, 1, 0);
    tk(6'b101010, 1); tk(6'b101010, 1);
    tk(6'b100011, 2); tk(6'b100011, 2); tk(6'b100011, 2);
    add(1, 0, 0, 0, 0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    run_vecs("oneshot");

    // Ping-pong with L=3 and L=0, then stop and stop+start collisions.
    wr(0, 6'b000001, 0); wr(1, 6'b000010, 0); wr(2, 6'b000100, 0); wr(3, 6'b001000, 0);
    add(1, 1, 0, 0, 2, 3, 6'b000001, 0, 1, 0);
    tk(6'b000010, 1); tk(6'b000100, 2); tk(6'b001000, 3); tk(6'b000100, 2);
    tk(6'b000010, 1); tk(6'b000001, 0); tk(6'b000010, 1); tk(6'b000100, 2);
    add(1, 1, 0, 0, 2, 0, 6'b000001, 0, 1, 0);
    tk(6'b000001, 0); tk(6'b000001, 0); tk(6'b000001, 0);
    add(0, 0, 1, 0, 0, 0, '0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 3, 6'b000001, 0, 1, 0);
    add(1, 1, 1, 0, 0, 3, '0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    run_vecs("ping");

    // Asynchronous reset while running on step 3.
    start = 1; mode = 0; last_step = 3; cyc(); start = 0;
    tick = 1; cyc(); cyc(); cyc(); tick = 0;
    chk_out("pre_rst", 6'b001000, 3, 1, 0);
    #3 rst = 0;
    #1 chk_out("async_rst", '0, 0, 0, 0);
    @(negedge clk); rst = 1;
    cyc();
    start = 1; mode = 0; last_step = 7; cyc(); start = 0;
    chk_out("zero_tab0", '0, 0, 1, 0);
    tick = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk_out($sformatf("zero_tab%0d", i), '0, SW'(i), 1, 0);
    end
    tick = 0;

    // Pause mid-dwell: step 0 must see exactly four unpaused ticks.
    wr(0, 6'b010101, 3); wr(1, 6'b110011, 0);
    start = 1; mode = 0; last_step = 1; cyc(); start = 0;
    tick = 1; cyc();
    pause = 1;
    for (int i = 0; i < 5; i++) cyc();
    chk_out("paused", 6'b010101, 0, 1, 0);
    pause = 0;
    cyc(); cyc();
    chk_out("resume_hold", 6'b010101, 0, 1, 0);
    cyc();
    chk_out("resume_adv", 6'b110011, 1, 1, 0);

    // Restart with a coincident tick: the tick must not count.
    start = 1; cyc(); start = 0;
    chk_out("restart", 6'b010101, 0, 1, 0);
    cyc(); cyc(); cyc();
    chk_out("restart_hold", 6'b010101, 0, 1, 0);
    cyc();
    chk_out("restart_adv", 6'b110011, 1, 1, 0);
    tick = 0;

    // Table writes during RUN take effect only on the next load.
    start = 1; cyc(); start = 0;
    tick = 1;
    wr(0, 6'b111000, 3);
    chk_out("wr_cur", 6'b010101, 0, 1, 0);
    cyc(); cyc();
    chk_out("wr_cur2", 6'b010101, 0, 1, 0);
    wr(1, 6'b000111, 0);
    chk_out("wr_same_cycle", 6'b110011, 1, 1, 0);
    cyc();
    chk_out("wr_reload0", 6'b111000, 0, 1, 0);
    cyc(); cyc(); cyc(); cyc();
    chk_out("wr_reload1", 6'b000111, 1, 1, 0);
    tick = 0;

    // Out-of-range last_step resolves to the final entry.
    for (int i = 0; i < 8; i++) wr(i, WIDTH'(i + 8), 0);
    lval = 15;
    start = 1; mode = 0; last_step = lval[SW-1:0]; cyc(); start = 0;
    tick = 1;
    for (int i = 0; i < 7; i++) cyc();
    chk_out("last15_s7", 6'd15, 7, 1, 0);
    cyc();
    chk_out("last15_wrap", 6'd8, 0, 1, 0);
    tick = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
